// File: rtl/div_pkg.sv
// ============================================================================
//  Module : div_pkg
//  Shared widths, FSM state encodings and handshake constants for the divider.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [RegBus-1:0] negate(input logic [RegBus-1:0] v);
    return ~v + {{(RegBus-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module : div_step
//  One radix-2 restoring iteration on the 65-bit {rem, quo} working register.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
  import div_pkg::*;
(
  input  logic [64:0]       work_i,
  input  logic [RegBus-1:0] divisor_i,
  output logic [64:0]       work_o
);

  logic [33:0] w_rem;
  logic [33:0] w_diff;

  // Shifted remainder carries one guard bit so the borrow is unambiguous.
  assign w_rem  = {work_i[64:32], work_i[31]};
  assign w_diff = w_rem - {2'b00, divisor_i};

  assign work_o = w_diff[33] ? {work_i[63:0], 1'b0}
                             : {w_diff[32:0], work_i[30:0], 1'b1};

endmodule

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
//  Module : div
//  Multi-cycle 32-bit signed/unsigned divider, result {remainder, quotient}.
//  Optional macro DIV_ZERO_EXC_EN adds the div_zero_o exception flag.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
`ifdef DIV_ZERO_EXC_EN
  ,
  output logic                    div_zero_o
`endif
);

  div_state_e              r_state, w_state;
  logic [5:0]              r_cnt, w_cnt;
  logic [64:0]             r_work, w_work;
  logic [RegBus-1:0]       r_divisor, w_divisor;
  logic                    r_sign1, w_sign1;
  logic                    r_sign2, w_sign2;
  logic [DoubleRegBus-1:0] r_result, w_result;
  logic                    r_ready, w_ready;
  logic                    r_div_zero, w_div_zero;
  logic [64:0]             w_step;
  logic [RegBus-1:0]       w_quo_fix, w_rem_fix;
  logic                    w_neg1, w_neg2;

  div_step u_step (
    .work_i    (r_work),
    .divisor_i (r_divisor),
    .work_o    (w_step)
  );

  assign w_neg1 = signed_div_i & opdata1_i[RegBus-1];
  assign w_neg2 = signed_div_i & opdata2_i[RegBus-1];

  // Sign fix-up on the final iteration's output; min/-1 wraps naturally.
  assign w_quo_fix = (r_sign1 ^ r_sign2) ? negate(w_step[31:0])  : w_step[31:0];
  assign w_rem_fix = r_sign1             ? negate(w_step[63:32]) : w_step[63:32];

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_work     = r_work;
    w_divisor  = r_divisor;
    w_sign1    = r_sign1;
    w_sign2    = r_sign2;
    w_result   = r_result;
    w_ready    = r_ready;
    w_div_zero = r_div_zero;
    if (annul_i) begin
      w_state    = DivFree;
      w_cnt      = 6'd0;
      w_result   = '0;
      w_ready    = DivResultNotReady;
      w_div_zero = 1'b0;
    end else begin
      unique case (r_state)
        DivFree: begin
          w_result = '0;
          w_ready  = DivResultNotReady;
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              w_state    = DivByZero;
              w_div_zero = 1'b1;
            end else begin
              w_state   = DivOn;
              w_cnt     = 6'd0;
              w_sign1   = w_neg1;
              w_sign2   = w_neg2;
              w_work    = {33'd0, (w_neg1 ? negate(opdata1_i) : opdata1_i)};
              w_divisor = w_neg2 ? negate(opdata2_i) : opdata2_i;
            end
          end
        end
        DivByZero: begin
          w_state  = DivEnd;
          w_result = '0;
          w_ready  = DivResultReady;
        end
        DivOn: begin
          w_work = w_step;
          w_cnt  = r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            w_state  = DivEnd;
            w_result = {w_rem_fix, w_quo_fix};
            w_ready  = DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            w_state    = DivFree;
            w_result   = '0;
            w_ready    = DivResultNotReady;
            w_div_zero = 1'b0;
          end
        end
        default: w_state = DivFree;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DivFree;
      r_cnt      <= 6'd0;
      r_work     <= '0;
      r_divisor  <= '0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_work     <= w_work;
      r_divisor  <= w_divisor;
      r_sign1    <= w_sign1;
      r_sign2    <= w_sign2;
      r_result   <= w_result;
      r_ready    <= w_ready;
      r_div_zero <= w_div_zero;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

`ifdef DIV_ZERO_EXC_EN
  assign div_zero_o = r_div_zero;
`else
  logic w_unused;
  assign w_unused = r_div_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
//  Module : tb_div
//  Self-checking bench for the div block using an expected-result queue.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_EXC_EN
  logic        div_zero_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_EXC_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request (after an edge) and records its expected result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(model(a, b, s));
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 100) begin
      tick();
      edges++;
      if (ready_o) return;
    end
  endtask

  task automatic test_reset();
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h want ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_divu_basic();
    int e;
    logic [63:0] x;
    launch(32'd100, 32'd7, 1'b0);
    wait_ready(e);
    x = exp_q.pop_front();
    total++;
    if (e !== 33 || result_o !== x || x !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL divu_100_7: edges=%0d result=%h want 33 %h", e, result_o, x);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ready_o !== 1'b1 || result_o !== x) begin
        bad++;
        $display("FAIL hold_stable: ready=%b result=%h want 1 %h", ready_o, result_o, x);
      end
    end
    start_i = 1'b0;
    tick();
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL drop_start: ready=%b result=%h want 0 0", ready_o, result_o);
    end
  endtask

  task automatic test_signed_and_boundaries();
    logic [31:0] a_t[5] = '{32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b_t[5] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1, 32'd3};
    logic        s_t[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int e;
    logic [63:0] x;
    for (int i = 0; i < 5; i++) begin
      launch(a_t[i], b_t[i], s_t[i]);
      wait_ready(e);
      x = exp_q.pop_front();
      total++;
      if (e !== 33 || result_o !== x) begin
        bad++;
        $display("FAIL signed_case%0d: edges=%0d result=%h want 33 %h", i, e, result_o, x);
      end
      start_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_div_zero();
    int e;
    logic [63:0] x;
    launch(32'd1234, 32'd0, 1'b1);
    wait_ready(e);
    x = exp_q.pop_front();
    total++;
    if (e !== 2 || result_o !== x) begin
      bad++;
      $display("FAIL div_zero: edges=%0d result=%h want 2 %h", e, result_o, x);
    end
`ifdef DIV_ZERO_EXC_EN
    total++;
    if (div_zero_o !== 1'b1) begin
      bad++;
      $display("FAIL div_zero_flag: got=%b want 1", div_zero_o);
    end
`endif
    start_i = 1'b0;
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL div_zero_release: ready=%b want 0", ready_o);
    end
  endtask

  task automatic test_annul();
    int e;
    logic [63:0] x;
    launch(32'd1000, 32'd7, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    void'(exp_q.pop_front());
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_mid: ready=%b result=%h want 0 0", ready_o, result_o);
    end
    launch(32'd9, 32'd3, 1'b0);
    wait_ready(e);
    x = exp_q.pop_front();
    total++;
    if (e !== 33 || result_o !== x || x !== {32'd0, 32'd3}) begin
      bad++;
      $display("FAIL after_annul: edges=%0d result=%h want 33 %h", e, result_o, x);
    end
    start_i = 1'b0;
    tick();
    // annul together with start: no divide may begin
    launch(32'd5, 32'd0, 1'b0);
    void'(exp_q.pop_front());
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL annul_with_start: ready=%b want 0", ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    logic [63:0] x;
    launch(32'd77, 32'd5, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    void'(exp_q.pop_front());
    rst = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b result=%h want 0 0", ready_o, result_o);
    end
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    // reset in DivEnd must clear a held result asynchronously
    launch(32'd50, 32'd3, 1'b0);
    wait_ready(e);
    void'(exp_q.pop_front());
    #2 rst = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_end: ready=%b result=%h want 0 0", ready_o, result_o);
    end
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    // operand changes after capture must not affect the result
    launch(32'd100, 32'd7, 1'b0);
    tick();
    tick();
    opdata1_i    = 32'd5000;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b1;
    wait_ready(e);
    x = exp_q.pop_front();
    total++;
    if (result_o !== x) begin
      bad++;
      $display("FAIL operand_latch: result=%h want %h", result_o, x);
    end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int e;
    logic [63:0] x;
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (i == 5) b = 32'hFFFF_FFFF;
      s = i[0] ^ i[1];
      launch(a, b, s);
      wait_ready(e);
      x = exp_q.pop_front();
      total++;
      if (e !== 33 || result_o !== x) begin
        bad++;
        $display("FAIL b2b%0d: %h/%h s=%b edges=%0d result=%h want %h",
                 i, a, b, s, e, result_o, x);
      end
      start_i = 1'b0;
      tick();
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst = 1'b1;
    tick();
    test_reset();
    test_divu_basic();
    test_signed_and_boundaries();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
